mdu_seq: RTL



---
 rtl/mdu_seq_pkg.sv | 30 +++
 rtl/mdu_div_step.sv | 28 ++
 rtl/mdu_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_pkg.sv
// +-----------------------------------------------------------------------+
// | mdu_seq_pkg : shared opcodes, FSM states and helpers for mdu_seq      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package mdu_seq_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  localparam int MDU_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (32'd0 - x) : x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_div_step.sv
// +-----------------------------------------------------------------------+
// | mdu_div_step : one combinational restoring-division step              |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module mdu_div_step (
  input  logic [31:0] i_rem,
  input  logic [31:0] i_quo,
  input  logic [31:0] i_dvsr,
  output logic [31:0] o_rem,
  output logic [31:0] o_quo
);

  logic [32:0] w_sh;
  logic [31:0] w_diff;
  logic        w_ok;

  // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
  assign w_sh   = {i_rem, i_quo[31]};
  assign w_ok   = (w_sh >= {1'b0, i_dvsr});
  assign w_diff = w_sh[31:0] - i_dvsr;
  assign o_rem  = w_ok ? w_diff : w_sh[31:0];
  assign o_quo  = {i_quo[30:0], w_ok};

endmodule

`default_nettype wire

// File: rtl/mdu_seq.sv
// +-----------------------------------------------------------------------+
// | mdu_seq : multi-cycle MULT/DIV sequencer owning HI/LO                 |
// | Divider built only when MDU_DIV_EN is defined.   Rev 1.0              |
// +-----------------------------------------------------------------------+
`default_nettype none

module mdu_seq
  import mdu_seq_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e  r_state, w_next_state;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc, r_mcand;
  logic [31:0] r_mq, r_hi, r_lo;
  logic        r_neg_q, r_done;

  logic        w_accept, w_is_mul, w_start, w_sgn, w_last;
  logic [31:0] w_mag_a, w_mag_b;
  logic [63:0] w_prod;

  assign busy      = (r_state != ST_IDLE);
  assign req_ready = !busy;
  assign done      = r_done;
  assign hi        = r_hi;
  assign lo        = r_lo;

  assign w_accept = req_valid && req_ready && !flush;
  assign w_is_mul = (req_op == MDU_MULT) || (req_op == MDU_MULTU);
  assign w_sgn    = (req_op == MDU_MULT) || (req_op == MDU_DIV);
  assign w_mag_a  = mag32(req_a, w_sgn);
  assign w_mag_b  = mag32(req_b, w_sgn);
  assign w_last   = (r_cnt == 5'(MDU_ITERS - 1));
  assign w_prod   = r_neg_q ? (64'd0 - r_acc) : r_acc;

`ifdef MDU_DIV_EN
  logic        r_is_div, r_neg_r;
  logic        w_is_div;
  logic [31:0] w_rem_nxt, w_quo_nxt;

  assign w_is_div = (req_op == MDU_DIV) || (req_op == MDU_DIVU);
  assign w_start  = w_is_mul || w_is_div;

  mdu_div_step u_div_step (
    .i_rem  (r_acc[31:0]),
    .i_quo  (r_mq),
    .i_dvsr (r_mcand[31:0]),
    .o_rem  (w_rem_nxt),
    .o_quo  (w_quo_nxt)
  );
`else
  assign w_start = w_is_mul;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_start) w_next_state = ST_ITER;
      ST_ITER: if (w_last) w_next_state = ST_FIX;
      ST_FIX:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
    if (flush) w_next_state = ST_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_mq    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_neg_q <= 1'b0;
      r_done  <= 1'b0;
`ifdef MDU_DIV_EN
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_cnt <= '0;
          r_acc <= '0;
          if (req_op == MDU_MTHI) r_hi <= req_a;
          if (req_op == MDU_MTLO) r_lo <= req_a;
          if (w_is_mul) begin
            r_mcand <= {32'd0, w_mag_a};
            r_mq    <= w_mag_b;
            r_neg_q <= (req_op == MDU_MULT) && (req_a[31] ^ req_b[31]);
`ifdef MDU_DIV_EN
            r_is_div <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
          end
`ifdef MDU_DIV_EN
          if (w_is_div) begin
            r_is_div <= 1'b1;
            // Zero divisor: run unsigned on the raw dividend so the loop yields lo=all-ones, hi=a.
            if (req_b == 32'd0) begin
              r_mq    <= req_a;
              r_mcand <= '0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_mq    <= w_mag_a;
              r_mcand <= {32'd0, w_mag_b};
              r_neg_q <= (req_op == MDU_DIV) && (req_a[31] ^ req_b[31]);
              r_neg_r <= (req_op == MDU_DIV) && req_a[31];
            end
          end
`endif
        end
        ST_ITER: begin
          r_cnt <= r_cnt + 5'd1;
`ifdef MDU_DIV_EN
          if (r_is_div) begin
            r_acc <= {32'd0, w_rem_nxt};
            r_mq  <= w_quo_nxt;
          end else
`endif
          begin
            if (r_mq[0]) r_acc <= r_acc + r_mcand;
            r_mcand <= {r_mcand[62:0], 1'b0};
            r_mq    <= {1'b0, r_mq[31:1]};
          end
        end
        ST_FIX: if (!flush) begin
`ifdef MDU_DIV_EN
          if (r_is_div) begin
            r_lo <= r_neg_q ? (32'd0 - r_mq) : r_mq;
            r_hi <= r_neg_r ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
          end else
`endif
          begin
            {r_hi, r_lo} <= w_prod;
          end
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
